pong_vga_renderer: RTL and testbench
====================================

// Module: pong_vga_renderer
// PURPOSE
// Consumer end of the game controller's position interface. Generates VGA raster timing,
// samples paddle/ball positions once per frame during vertical blanking, and drives
// per-pixel RGB so both paddles and the ball are drawn tear-free. Sits between
// game_controller and the board's VGA DAC pins.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line; H_FRONT 16; H_SYNC 96; H_BACK 48 (clocks)
// V_ACTIVE 480 visible lines/frame; V_FRONT 10; V_SYNC 2; V_BACK 33 (lines)
// PADDLE_1_X 16 left edge of left paddle; PADDLE_2_X 616 left edge of right paddle
// PADDLE_WIDTH 8; PADDLE_HEIGHT 64; BALL_SIDE_SIZE 8 (pixels)
// FG_COLOR 12'hFFF object colour; BG_COLOR 12'h000 playfield colour
// Derived: H_TOTAL=sum of H_*; V_TOTAL=sum of V_*; HW=$clog2(H_ACTIVE+1); VW=$clog2(V_ACTIVE+1)
// PORTS
// clk           in   1      pixel clock
// rst           in   1      asynchronous reset, active low
// paddle_1_pos  in   VW+1   left paddle top Y
// paddle_2_pos  in   VW+1   right paddle top Y
// ball_pos_x    in   HW+1   ball left X
// ball_pos_y    in   VW+1   ball top Y
// hsync         out  1      horizontal sync, active low
// vsync         out  1      vertical sync, active low
// de            out  1      high while in visible area
// rgb           out  12     {r[3:0],g[3:0],b[3:0]}
// frame_start   out  1      one-clock pulse when positions are sampled
// BEHAVIOUR
// - Reset (rst=0): h_cnt=0, v_cnt=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0,
//   latched positions=0. Release takes effect on next clk edge.
// - h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments only on h_cnt wrap, 0..V_TOTAL-1, wraps.
// - Visible: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hsync low for h_cnt in
//   [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC); vsync low for v_cnt in
//   [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
// - All outputs registered: hsync/vsync/de/rgb at edge N reflect counters before edge N
//   (1-clock latency, outputs mutually aligned).
// - Sampling: in the clock where h_cnt==H_TOTAL-1 && v_cnt==V_ACTIVE-1, all four position
//   inputs are captured into shadow registers at that edge; frame_start=1 for exactly the
//   following clock. Inputs are ignored at all other times; rendering uses shadows only.
// - Hit test, visible pixel (x=h_cnt, y=v_cnt), half-open ranges:
//   paddle1: PADDLE_1_X<=x<PADDLE_1_X+PADDLE_WIDTH && p1<=y<p1+PADDLE_HEIGHT
//   paddle2: same with PADDLE_2_X, p2; ball: bx<=x<bx+BALL_SIDE_SIZE && by<=y<by+BALL_SIDE_SIZE
// - Upper bounds computed one bit wider than the position, unsigned; no wrap-around;
//   objects extending past the active area are clipped by de.
// - rgb=FG_COLOR on any hit (overlap same colour), BG_COLOR if visible with no hit,
//   12'h000 whenever not visible.
// - Reset mid-frame: counters and shadows cleared immediately; drawing resumes from (0,0)
//   with zeroed shadows until the next sampling point.
// TESTING
// 1 Reset then 1 frame free-run -> hsync period 800 clk, low 96 clk from h=656; vsync
//   period 525 lines, low lines 490-491; de high 640 clk/line on 480 lines.
// 2 p1=100, p2=200, bx=320, by=240 held -> rgb=FFF exactly at x16-23/y100-163,
//   x616-623/y200-263, x320-327/y240-247; elsewhere visible 000.
// 3 Change ball_pos_x 320->330 mid-frame (v=100) -> current frame still draws at 320;
//   next frame at 330; frame_start pulses once/frame, clock after h=799,v=479.
// 4 p1=450 -> paddle drawn on lines 450-479 only; no pixels on lines 0-33 (no wrap).
// 5 Ball at bx=16, by=100 overlapping paddle 1 -> overlap region FFF, no X/glitch.
// 6 Assert rst at h=300,v=200 for 3 clk -> hsync=vsync=1, de=0, rgb=0 during reset;
//   first de after release at clock 1, counters from 0.

Source files
------------

// File: rtl/pong_vga_renderer.sv
// rtl/pong_vga_renderer.sv - VGA raster timing and paddle/ball renderer
//
// Generates VGA raster timing and draws two paddles and a ball on a flat
// background. Object positions are captured once per frame, at the last clock
// of the last visible line, so every visible frame is drawn from a single
// consistent set of positions and does not tear.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active low
//   paddle_1_pos in   left paddle top Y
//   paddle_2_pos in   right paddle top Y
//   ball_pos_x   in   ball left X
//   ball_pos_y   in   ball top Y
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   de           out  high while the registered pixel is in the visible area
//   rgb          out  {r[3:0],g[3:0],b[3:0]}
//   frame_start  out  one-clock pulse in the clock after positions are captured
module pong_vga_renderer #(
  parameter int          H_ACTIVE       = 640,
  parameter int          H_FRONT        = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BACK         = 48,
  parameter int          V_ACTIVE       = 480,
  parameter int          V_FRONT        = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BACK         = 33,
  parameter int          PADDLE_1_X     = 16,
  parameter int          PADDLE_2_X     = 616,
  parameter int          PADDLE_WIDTH   = 8,
  parameter int          PADDLE_HEIGHT  = 64,
  parameter int          BALL_SIDE_SIZE = 8,
  parameter logic [11:0] FG_COLOR       = 12'hFFF,
  parameter logic [11:0] BG_COLOR       = 12'h000,
  localparam int         HW             = $clog2(H_ACTIVE + 1),
  localparam int         VW             = $clog2(V_ACTIVE + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [VW:0] paddle_1_pos,
  input  logic [VW:0] paddle_2_pos,
  input  logic [HW:0] ball_pos_x,
  input  logic [VW:0] ball_pos_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  // Hit-test arithmetic is one bit wider than the positions so that
  // position + size never wraps back into the visible area.
  localparam int XW      = HW + 2;
  localparam int YW      = VW + 2;

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic [VW:0]    p1_q, p1_d, p2_q, p2_d, by_q, by_d;
  logic [HW:0]    bx_q, bx_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [11:0]    rgb_q, rgb_d;

  logic           h_last, v_last, visible, sample_pt;
  logic [XW-1:0]  x, bx_lo, bx_hi;
  logic [YW-1:0]  y, p1_lo, p1_hi, p2_lo, p2_hi, by_lo, by_hi;
  logic           hit_p1, hit_p2, hit_ball;

  always_comb begin
    h_last    = (h_cnt_q == HCW'(H_TOTAL - 1));
    v_last    = (v_cnt_q == VCW'(V_TOTAL - 1));
    visible   = (h_cnt_q < HCW'(H_ACTIVE)) && (v_cnt_q < VCW'(V_ACTIVE));
    sample_pt = h_last && (v_cnt_q == VCW'(V_ACTIVE - 1));

    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end

    // Shadow registers: inputs are only looked at on the sampling clock.
    p1_d = sample_pt ? paddle_1_pos : p1_q;
    p2_d = sample_pt ? paddle_2_pos : p2_q;
    bx_d = sample_pt ? ball_pos_x   : bx_q;
    by_d = sample_pt ? ball_pos_y   : by_q;
    fs_d = sample_pt;

    x     = XW'(h_cnt_q);
    y     = YW'(v_cnt_q);
    p1_lo = YW'(p1_q);
    p1_hi = YW'(p1_q) + YW'(PADDLE_HEIGHT);
    p2_lo = YW'(p2_q);
    p2_hi = YW'(p2_q) + YW'(PADDLE_HEIGHT);
    bx_lo = XW'(bx_q);
    bx_hi = XW'(bx_q) + XW'(BALL_SIDE_SIZE);
    by_lo = YW'(by_q);
    by_hi = YW'(by_q) + YW'(BALL_SIDE_SIZE);

    hit_p1   = (x >= XW'(PADDLE_1_X)) && (x < XW'(PADDLE_1_X + PADDLE_WIDTH)) &&
               (y >= p1_lo) && (y < p1_hi);
    hit_p2   = (x >= XW'(PADDLE_2_X)) && (x < XW'(PADDLE_2_X + PADDLE_WIDTH)) &&
               (y >= p2_lo) && (y < p2_hi);
    hit_ball = (x >= bx_lo) && (x < bx_hi) && (y >= by_lo) && (y < by_hi);

    hsync_d = !((h_cnt_q >= HCW'(H_ACTIVE + H_FRONT)) &&
                (h_cnt_q <  HCW'(H_ACTIVE + H_FRONT + H_SYNC)));
    vsync_d = !((v_cnt_q >= VCW'(V_ACTIVE + V_FRONT)) &&
                (v_cnt_q <  VCW'(V_ACTIVE + V_FRONT + V_SYNC)));
    de_d    = visible;
    rgb_d   = 12'h000;
    if (visible) begin
      rgb_d = (hit_p1 || hit_p2 || hit_ball) ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 12'h000;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb/tb_pong_vga_renderer.sv - directed self-checking bench for pong_vga_renderer
module tb_pong_vga_renderer;

  // Scaled-down raster so whole frames fit in a short run.
  localparam int HA = 40, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int P1X = 2, P2X = 34, PWD = 3, PHT = 8, BSZ = 4;
  localparam int FR = HT * VT;
  localparam int HW = $clog2(HA + 1);
  localparam int VW = $clog2(VA + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [VW:0] p1, p2, by;
  logic [HW:0] bx;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  pong_vga_renderer #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PADDLE_1_X(P1X), .PADDLE_2_X(P2X), .PADDLE_WIDTH(PWD),
    .PADDLE_HEIGHT(PHT), .BALL_SIDE_SIZE(BSZ),
    .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk), .rst(rst),
    .paddle_1_pos(p1), .paddle_2_pos(p2), .ball_pos_x(bx), .ball_pos_y(by),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hx, vy;
  int s_p1, s_p2, s_bx, s_by;
  int n_hs, n_vs, n_de, n_fg, n_fs, fs_x, fs_y, hs_x, vs_y, mism, mism_x, mism_y;
  int col_cnt [HA];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_hs = 0; n_vs = 0; n_de = 0; n_fg = 0; n_fs = 0;
    fs_x = -1; fs_y = -1; hs_x = -1; vs_y = -1;
    mism = 0; mism_x = -1; mism_y = -1;
    for (int i = 0; i < HA; i++) col_cnt[i] = 0;
  endtask

  function automatic logic hit(input int x, input int y);
    return (x >= P1X && x < P1X + PWD && y >= s_p1 && y < s_p1 + PHT) ||
           (x >= P2X && x < P2X + PWD && y >= s_p2 && y < s_p2 + PHT) ||
           (x >= s_bx && x < s_bx + BSZ && y >= s_by && y < s_by + BSZ);
  endfunction

  // One pixel clock: outputs after the edge must reflect the counters before it.
  task automatic step();
    int px, py;
    logic ehs, evs, ede, efs;
    logic [11:0] er;
    logic samp;
    px   = hx;
    py   = vy;
    ede  = (px < HA) && (py < VA);
    ehs  = !(px >= HA + HF && px < HA + HF + HS);
    evs  = !(py >= VA + VF && py < VA + VF + VS);
    er   = ede ? (hit(px, py) ? 12'hFFF : 12'h000) : 12'h000;
    samp = (px == HT - 1) && (py == VA - 1);
    efs  = samp;
    if (samp) begin
      s_p1 = int'(p1); s_p2 = int'(p2); s_bx = int'(bx); s_by = int'(by);
    end
    @(posedge clk);
    #1;
    if (hx == HT - 1) begin
      hx = 0;
      vy = (vy == VT - 1) ? 0 : vy + 1;
    end else begin
      hx = hx + 1;
    end
    if ({hsync, vsync, de, rgb, frame_start} !== {ehs, evs, ede, er, efs}) begin
      if (mism == 0) begin
        mism_x = px; mism_y = py;
      end
      mism++;
    end
    if (hsync === 1'b0) begin
      n_hs++;
      if (hs_x < 0) hs_x = px;
    end
    if (vsync === 1'b0) begin
      n_vs++;
      if (vs_y < 0) vs_y = py;
    end
    if (de === 1'b1) n_de++;
    if (rgb === 12'hFFF) begin
      n_fg++;
      if (px < HA) col_cnt[px]++;
    end
    if (frame_start === 1'b1) begin
      n_fs++; fs_x = px; fs_y = py;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_model(input string tag);
    chk($sformatf("%s_model(first x=%0d y=%0d)", tag, mism_x, mism_y), mism, 0);
  endtask

  initial begin
    p1 = 6'd5; p2 = 6'd10; bx = 7'd20; by = 6'd12;
    s_p1 = 0; s_p2 = 0; s_bx = 0; s_by = 0;
    hx = 0; vy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({hsync, vsync, de, rgb, frame_start}), int'(16'hC000));
    rst = 1'b1;

    // Frame 1: raster timing from reset, zeroed shadows.
    clear_stats();
    run(FR);
    chk("f1_hsync_low_clks", n_hs, HS * VT);
    chk("f1_hsync_first_low_x", hs_x, 44);
    chk("f1_vsync_low_clks", n_vs, VS * HT);
    chk("f1_vsync_first_low_y", vs_y, 32);
    chk("f1_de_clks", n_de, 1200);
    chk("f1_frame_start_count", n_fs, 1);
    chk("f1_frame_start_x", fs_x, 55);
    chk("f1_frame_start_y", fs_y, 29);
    chk("f1_fg_pixels", n_fg, 56);
    chk_model("f1");

    // Frame 2: positions captured at end of frame 1.
    clear_stats();
    run(FR);
    chk("f2_fg_pixels", n_fg, 64);
    chk("f2_col2", col_cnt[2], 8);
    chk("f2_col34", col_cnt[34], 8);
    chk("f2_col20", col_cnt[20], 4);
    chk_model("f2");

    // Frame 3: ball X changes mid-frame; still drawn at the old X.
    clear_stats();
    run(10 * HT);
    bx = 7'd25;
    run(FR - 10 * HT);
    chk("f3_fg_pixels", n_fg, 64);
    chk("f3_col20", col_cnt[20], 4);
    chk("f3_col27", col_cnt[27], 0);
    chk("f3_frame_start_count", n_fs, 1);
    chk_model("f3");

    // Frame 4: ball at new X; paddle near bottom queued for next frame.
    p1 = 6'd26; p2 = 6'd0; bx = 7'd50; by = 6'd0;
    clear_stats();
    run(FR);
    chk("f4_fg_pixels", n_fg, 64);
    chk("f4_col20", col_cnt[20], 0);
    chk("f4_col27", col_cnt[27], 4);
    chk_model("f4");

    // Frame 5: paddle 1 at y=26 clipped to lines 26-29, no wrap to the top.
    p1 = 6'd4; p2 = 6'd20; bx = 7'd2; by = 6'd6;
    clear_stats();
    run(FR);
    chk("f5_fg_pixels", n_fg, 36);
    chk("f5_col2", col_cnt[2], 4);
    chk("f5_col34", col_cnt[34], 8);
    chk_model("f5");

    // Frame 6: ball overlapping paddle 1.
    clear_stats();
    run(FR);
    chk("f6_fg_pixels", n_fg, 52);
    chk("f6_col2", col_cnt[2], 8);
    chk("f6_col5", col_cnt[5], 4);
    chk_model("f6");

    // Frame 7: reset mid-frame at h=30, v=20 for three clocks.
    clear_stats();
    run(20 * HT + 30);
    chk("f7_pre_reset_x", hx, 30);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", int'({hsync, vsync, de, rgb, frame_start}), int'(16'hC000));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold_outputs_%0d", i),
          int'({hsync, vsync, de, rgb, frame_start}), int'(16'hC000));
    end
    rst = 1'b1;
    hx = 0; vy = 0;
    s_p1 = 0; s_p2 = 0; s_bx = 0; s_by = 0;
    clear_stats();
    step();
    chk("post_reset_first_de", int'(de), 1);
    run(FR - 1);
    chk("post_reset_fg_pixels", n_fg, 56);
    chk("post_reset_frame_start_count", n_fs, 1);
    chk("post_reset_hsync_first_low_x", hs_x, 44);
    chk_model("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
